// File: rtl/mips_control_unit_if.sv
// Instruction-field and status bundle between the fetch/decode logic of mips_core
// and the execute/control unit.
interface mips_control_unit_if;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic [4:0]  rd_num;
  logic [4:0]  sh_amount;
  logic [15:0] imm;
  logic [15:0] pc_branch;
  logic        halted_signal;

  modport master (
    output opcode, func, rs_num, rt_num, rd_num, sh_amount, imm,
    input  pc_branch, halted_signal
  );

  modport slave (
    input  opcode, func, rs_num, rt_num, rd_num, sh_amount, imm,
    output pc_branch, halted_signal
  );
endinterface

// File: rtl/mips_control_unit.sv
// Single-cycle MIPS execute/control: register file, ALU, branch offset and sticky halt.
// Define CU_MULDIV_EN to add HI/LO with mult/multu/div/divu/mfhi/mflo.
module mips_control_unit #(
  parameter logic [5:0] HALT_FUNC = 6'h0C
) (
  input  logic               clk,
  input  logic               rst_b,
  mips_control_unit_if.slave cu
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
`ifdef CU_MULDIV_EN
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        halted_q;
  logic        halted_d;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        is_halt;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        branch_taken;
  logic [15:0] branch_off;

  assign rs_val   = regs_q[cu.rs_num];
  assign rt_val   = regs_q[cu.rt_num];
  assign imm_sext = {{16{cu.imm[15]}}, cu.imm};
  assign imm_zext = {16'h0000, cu.imm};
  assign is_halt  = (cu.opcode == OP_RTYPE) && (cu.func == HALT_FUNC);

  // Low 16 bits of (sext(imm) << 2) + 4; the upper sign bits fall off anyway.
  assign branch_off = {cu.imm[13:0], 2'b00} + 16'd4;

`ifdef CU_MULDIV_EN
  logic [31:0] hi_q;
  logic [31:0] hi_d;
  logic [31:0] lo_q;
  logic [31:0] lo_d;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
  assign quot_s = $signed(rs_val) / $signed(rt_val);
  assign rem_s  = $signed(rs_val) % $signed(rt_val);
  assign quot_u = rs_val / rt_val;
  assign rem_u  = rs_val % rt_val;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!halted_q && (cu.opcode == OP_RTYPE) && !is_halt) begin
      case (cu.func)
        F_MULT: begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
        F_MULTU: begin
          hi_d = prod_u[63:32];
          lo_d = prod_u[31:0];
        end
        F_DIV: begin
          if (rt_val != 32'h0) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end
        end
        F_DIVU: begin
          if (rt_val != 32'h0) begin
            hi_d = rem_u;
            lo_d = quot_u;
          end
        end
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
`endif

  always_comb begin
    wr_en        = 1'b0;
    wr_addr      = cu.rd_num;
    wr_data      = 32'h0;
    branch_taken = 1'b0;
    if (!halted_q && !is_halt) begin
      if (cu.opcode == OP_RTYPE) begin
        wr_en   = 1'b1;
        wr_addr = cu.rd_num;
        case (cu.func)
          F_ADD, F_ADDU: wr_data = rs_val + rt_val;
          F_SUB, F_SUBU: wr_data = rs_val - rt_val;
          F_AND:         wr_data = rs_val & rt_val;
          F_OR:          wr_data = rs_val | rt_val;
          F_XOR:         wr_data = rs_val ^ rt_val;
          F_NOR:         wr_data = ~(rs_val | rt_val);
          F_SLT:         wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
          F_SLTU:        wr_data = {31'h0, rs_val < rt_val};
          F_SLL:         wr_data = rt_val << cu.sh_amount;
          F_SRL:         wr_data = rt_val >> cu.sh_amount;
          F_SRA:         wr_data = $signed(rt_val) >>> cu.sh_amount;
          F_SLLV:        wr_data = rt_val << rs_val[4:0];
          F_SRLV:        wr_data = rt_val >> rs_val[4:0];
          F_SRAV:        wr_data = $signed(rt_val) >>> rs_val[4:0];
`ifdef CU_MULDIV_EN
          F_MFHI:        wr_data = hi_q;
          F_MFLO:        wr_data = lo_q;
`endif
          default:       wr_en   = 1'b0;
        endcase
      end else begin
        wr_en   = 1'b1;
        wr_addr = cu.rt_num;
        case (cu.opcode)
          OP_ADDI, OP_ADDIU: wr_data = rs_val + imm_sext;
          OP_SLTI:           wr_data = {31'h0, $signed(rs_val) < $signed(imm_sext)};
          OP_SLTIU:          wr_data = {31'h0, rs_val < imm_sext};
          OP_ANDI:           wr_data = rs_val & imm_zext;
          OP_ORI:            wr_data = rs_val | imm_zext;
          OP_XORI:           wr_data = rs_val ^ imm_zext;
          OP_LUI:            wr_data = {cu.imm, 16'h0000};
          OP_BEQ: begin
            wr_en        = 1'b0;
            branch_taken = (rs_val == rt_val);
          end
          OP_BNE: begin
            wr_en        = 1'b0;
            branch_taken = (rs_val != rt_val);
          end
          OP_BLEZ: begin
            wr_en        = 1'b0;
            branch_taken = $signed(rs_val) <= 32'sd0;
          end
          OP_BGTZ: begin
            wr_en        = 1'b0;
            branch_taken = $signed(rs_val) > 32'sd0;
          end
          default:           wr_en   = 1'b0;
        endcase
      end
    end
  end

  // r0 is never written, so it holds its reset value of zero forever.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != 5'd0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    halted_d = halted_q | is_halt;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
      halted_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      halted_q <= halted_d;
    end
  end

  assign cu.pc_branch     = (branch_taken && !halted_q && !rst_b) ? branch_off : 16'h0000;
  assign cu.halted_signal = halted_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Scoreboarded bench for mips_control_unit: a behavioural register/HI/LO model
// predicts pc_branch and halted_signal for every issued instruction.
module tb_mips_control_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic        halt;
  } exp_t;

  logic clk;
  logic rst_b;
  mips_control_unit_if cu();

  mips_control_unit #(.HALT_FUNC(6'h0C)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .cu    (cu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          txn    = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          m_halt;

  logic [5:0] rfuncs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] iops   [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0] mdfuncs[4]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};
  logic [5:0] junkops[4]  = '{6'h02, 6'h20, 6'h2B, 6'h3F};
  logic [5:0] junkfns[4]  = '{6'h01, 6'h05, 6'h08, 6'h3F};

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hi   = 32'h0;
    m_lo   = 32'h0;
    m_halt = 1'b0;
  endtask

  // Architectural meaning of one instruction, in plain integer arithmetic.
  task automatic model_exec(input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] im, output logic [15:0] pc);
    logic [31:0] a, b, r, uimm;
    logic [63:0] p;
    int          ia, ib, simm;
    bit          w, taken;
    logic [4:0]  dst;
    a = m_regs[rs];
    b = m_regs[rt];
    ia = int'(a);
    ib = int'(b);
    simm = int'($signed(im));
    uimm = 32'(simm);
    pc = 16'h0;
    r = 32'h0;
    w = 1'b0;
    taken = 1'b0;
    dst = rd;
    p = 64'h0;
    if (m_halt) return;
    if (op == 6'h00) begin
      w = 1'b1;
      case (fn)
        6'h20, 6'h21: r = a + b;
        6'h22, 6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = {31'h0, ia < ib};
        6'h2B: r = {31'h0, a < b};
        6'h00: r = b << sh;
        6'h02: r = b >> sh;
        6'h03: r = 32'(ib >>> sh);
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: r = 32'(ib >>> a[4:0]);
        6'h0C: begin w = 1'b0; m_halt = 1'b1; end
`ifdef CU_MULDIV_EN
        6'h18: begin w = 1'b0; p = 64'(longint'(ia) * longint'(ib)); m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin w = 1'b0; p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h1A: begin w = 1'b0; if (b != 0) begin m_lo = 32'(ia / ib); m_hi = 32'(ia % ib); end end
        6'h1B: begin w = 1'b0; if (b != 0) begin m_lo = a / b; m_hi = a % b; end end
        6'h10: r = m_hi;
        6'h12: r = m_lo;
`endif
        default: w = 1'b0;
      endcase
    end else begin
      w = 1'b1;
      dst = rt;
      case (op)
        6'h08, 6'h09: r = a + uimm;
        6'h0A: r = {31'h0, ia < simm};
        6'h0B: r = {31'h0, a < uimm};
        6'h0C: r = a & {16'h0, im};
        6'h0D: r = a | {16'h0, im};
        6'h0E: r = a ^ {16'h0, im};
        6'h0F: r = {im, 16'h0};
        6'h04: begin w = 1'b0; taken = (a == b); end
        6'h05: begin w = 1'b0; taken = (a != b); end
        6'h06: begin w = 1'b0; taken = (ia <= 0); end
        6'h07: begin w = 1'b0; taken = (ia > 0); end
        default: w = 1'b0;
      endcase
    end
    if (taken) pc = 16'(simm * 4 + 4);
    if (w && dst != 0) m_regs[dst] = r;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [15:0] im);
    cu.opcode    = op;
    cu.func      = fn;
    cu.rs_num    = rs;
    cu.rt_num    = rt;
    cu.rd_num    = rd;
    cu.sh_amount = sh;
    cu.imm       = im;
  endtask

  task automatic issue_now(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] im);
    exp_t e;
    drive(op, fn, rs, rt, rd, sh, im);
    e.halt = m_halt;
    model_exec(op, fn, rs, rt, rd, sh, im, e.pc);
    q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [15:0] im);
    @(posedge clk);
    #1;
    issue_now(op, fn, rs, rt, rd, sh, im);
  endtask

  task automatic r_op(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh);
    issue(6'h00, fn, rs, rt, rd, sh, {rd, sh, fn});
  endtask

  task automatic i_op(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [15:0] im);
    issue(op, im[5:0], rs, rt, im[15:11], im[10:6], im);
  endtask

  task automatic load32(input logic [4:0] r, input logic [31:0] v);
    i_op(6'h0F, r, 5'd0, v[31:16]);
    i_op(6'h0D, r, r, v[15:0]);
  endtask

  // Make a register's full value visible: rebuild the expected value in r30, then beq.
  task automatic probe(input logic [4:0] r);
    logic [15:0] im;
    im = 16'($urandom_range(0, 16'h3FFF));
    load32(5'd30, m_regs[r]);
    i_op(6'h04, 5'd30, r, im);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    model_reset();
    drive(6'h04, 6'h01, 5'd5, 5'd6, 5'd0, 5'd0, 16'h0001);
    e.pc = 16'h0;
    e.halt = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    issue_now(6'h04, 6'h01, 5'd5, 5'd6, 5'd0, 5'd0, 16'h0001);
  endtask

  // Reset raised between edges while halted: flags must clear before any edge.
  task automatic async_reset_check();
    exp_t e;
    @(posedge clk);
    #1;
    drive(6'h08, 6'h09, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0009);
    rst_b = 1'b1;
    model_reset();
    e.pc = 16'h0;
    e.halt = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    issue_now(6'h04, 6'h05, 5'd1, 5'd0, 5'd0, 5'd0, 16'h0005);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        txn++;
        if (cu.pc_branch !== e.pc || cu.halted_signal !== e.halt) begin
          errors++;
          $display("FAIL txn %0d pc_branch/halted: got %h/%b expected %h/%b",
                   txn, cu.pc_branch, cu.halted_signal, e.pc, e.halt);
        end else begin
          $display("txn %0d op=%h fn=%h pc_branch=%h halted=%b ok",
                   txn, cu.opcode, cu.func, cu.pc_branch, cu.halted_signal);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int         k;
    logic [4:0] s, t, d, sh;
    logic [15:0] im;
    rst_b = 1'b1;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    model_reset();

    do_reset();
    i_op(6'h08, 5'd0, 5'd0, 16'h0007);
    i_op(6'h04, 5'd7, 5'd0, 16'hFFFE);
    i_op(6'h08, 5'd1, 5'd0, 16'h0005);
    i_op(6'h08, 5'd2, 5'd0, 16'h0005);
    i_op(6'h04, 5'd2, 5'd1, 16'h0003);
    i_op(6'h05, 5'd2, 5'd1, 16'h0003);
    i_op(6'h0F, 5'd3, 5'd0, 16'h8000);
    i_op(6'h06, 5'd0, 5'd3, 16'h0002);
    i_op(6'h07, 5'd0, 5'd3, 16'h0002);
    r_op(6'h03, 5'd4, 5'd0, 5'd3, 5'd4);
    i_op(6'h0F, 5'd6, 5'd0, 16'hF800);
    i_op(6'h04, 5'd6, 5'd4, 16'h0002);
    i_op(6'h04, 5'd0, 5'd0, 16'hFFFF);
    i_op(6'h04, 5'd0, 5'd0, 16'h7FFF);

`ifdef CU_MULDIV_EN
    i_op(6'h08, 5'd1, 5'd0, 16'hFFFD);
    i_op(6'h08, 5'd2, 5'd0, 16'h0002);
    r_op(6'h18, 5'd0, 5'd1, 5'd2, 5'd0);
    r_op(6'h12, 5'd3, 5'd0, 5'd0, 5'd0);
    r_op(6'h10, 5'd4, 5'd0, 5'd0, 5'd0);
    load32(5'd30, 32'hFFFFFFFA);
    i_op(6'h04, 5'd30, 5'd3, 16'h0010);
    load32(5'd30, 32'hFFFFFFFF);
    i_op(6'h04, 5'd30, 5'd4, 16'h0011);
`endif

    for (int i = 1; i < 30; i++) load32(5'(i), $urandom);

    for (int it = 0; it < 150; it++) begin
      k  = $urandom_range(0, 11);
      s  = 5'($urandom_range(0, 29));
      t  = 5'($urandom_range(0, 29));
      d  = 5'($urandom_range(0, 29));
      sh = 5'($urandom_range(0, 31));
      im = 16'($urandom);
      if (k <= 3) begin
        r_op(rfuncs[$urandom_range(0, 15)], d, s, t, sh);
        probe(d);
      end else if (k <= 6) begin
        i_op(iops[$urandom_range(0, 7)], d, s, im);
        probe(d);
      end else if (k <= 8) begin
        if ($urandom_range(0, 2) == 0) t = s;
        i_op(6'($urandom_range(4, 7)), t, s, im);
      end else if (k == 9) begin
        r_op(mdfuncs[$urandom_range(0, 3)], 5'd0, s, t, 5'd0);
        r_op(6'h10, d, 5'd0, 5'd0, 5'd0);
        probe(d);
        r_op(6'h12, d, 5'd0, 5'd0, 5'd0);
        probe(d);
      end else if (k == 10) begin
        i_op(junkops[$urandom_range(0, 3)], d, s, im);
        probe(d);
      end else begin
        r_op(junkfns[$urandom_range(0, 3)], d, s, t, sh);
        probe(d);
      end
    end

    r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0);
    i_op(6'h08, 5'd1, 5'd0, 16'h1234);
    i_op(6'h04, 5'd0, 5'd0, 16'h0001);
    r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0);
    async_reset_check();
    i_op(6'h08, 5'd1, 5'd0, 16'h0003);
    probe(5'd1);
    r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0);
    i_op(6'h04, 5'd0, 5'd0, 16'h0001);
    do_reset();
    i_op(6'h07, 5'd0, 5'd1, 16'h0001);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
